// File: rtl/traffic_phase_sched.sv
// ============================================================================
// Module   : traffic_phase_sched
// Brief    : Demand-actuated two-road phase scheduler with emergency all-red.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_phase_sched #(
   parameter int TICK_DIV = 4,
   parameter int G_MIN    = 3,
   parameter int G_MAX    = 6,
   parameter int Y_T      = 1,
   parameter int AR_T     = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic       emg,
   output logic [2:0] TRC0,
   output logic [2:0] TRC1,
   output logic [2:0] phase,
   output logic [1:0] pend
);

   localparam logic [2:0] c_G0  = 3'd0;
   localparam logic [2:0] c_Y0  = 3'd1;
   localparam logic [2:0] c_AR0 = 3'd2;
   localparam logic [2:0] c_G1  = 3'd3;
   localparam logic [2:0] c_Y1  = 3'd4;
   localparam logic [2:0] c_AR1 = 3'd5;
   localparam logic [2:0] c_EMG = 3'd6;

   localparam logic [7:0] c_DIV_LAST = 8'(TICK_DIV - 1);
   localparam logic [7:0] c_G_MIN    = 8'(G_MIN);
   localparam logic [7:0] c_G_MAX    = 8'(G_MAX);
   localparam logic [7:0] c_Y_T      = 8'(Y_T);
   localparam logic [7:0] c_AR_T     = 8'(AR_T);

   localparam logic [2:0] c_RED = 3'b100;
   localparam logic [2:0] c_YEL = 3'b010;
   localparam logic [2:0] c_GRN = 3'b001;

   logic [2:0] state_q, state_d;
   logic [7:0] div_q, div_d;
   logic [7:0] t_q, t_d;
   logic [1:0] pend_q, pend_d;
   logic       w_tick;
   logic [7:0] w_elapsed;
   logic       w_change;

   assign w_tick    = (div_q == c_DIV_LAST);
   assign w_elapsed = t_q + 8'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= c_G0;
         div_q   <= 8'd0;
         t_q     <= 8'd0;
         pend_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         t_q     <= t_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (emg) begin
         state_d = c_EMG;
      end else begin
         case (state_q)
            c_G0:  if (w_tick && (((w_elapsed >= c_G_MIN) && pend_q[1]) || (w_elapsed == c_G_MAX)))
                      state_d = c_Y0;
            c_Y0:  if (w_tick && (w_elapsed == c_Y_T))  state_d = c_AR0;
            c_AR0: if (w_tick && (w_elapsed == c_AR_T)) state_d = c_G1;
            c_G1:  if (w_tick && (((w_elapsed >= c_G_MIN) && pend_q[0]) || (w_elapsed == c_G_MAX)))
                      state_d = c_Y1;
            c_Y1:  if (w_tick && (w_elapsed == c_Y_T))  state_d = c_AR1;
            c_AR1: if (w_tick && (w_elapsed == c_AR_T)) state_d = c_G0;
            default: state_d = c_AR1;  // EMG release and illegal code 7 both clear through AR1
         endcase
      end

      w_change = (state_d != state_q);
      if (w_change) begin
         div_d = 8'd0;
         t_d   = 8'd0;
      end else if (w_tick) begin
         div_d = 8'd0;
         t_d   = t_q + 8'd1;
      end else begin
         div_d = div_q + 8'd1;
         t_d   = t_q;
      end

      // Entry into a green serves that road's demand; entry beats a same-cycle request.
      pend_d[0] = ((state_d == c_G0) && (state_q != c_G0)) ? 1'b0 : (pend_q[0] | req0);
      pend_d[1] = ((state_d == c_G1) && (state_q != c_G1)) ? 1'b0 : (pend_q[1] | req1);
   end

   always_comb begin
      TRC0  = c_RED;
      TRC1  = c_RED;
      phase = state_q;
      pend  = pend_q;
      case (state_q)
         c_G0:    TRC0 = c_GRN;
         c_Y0:    TRC0 = c_YEL;
         c_G1:    TRC1 = c_GRN;
         c_Y1:    TRC1 = c_YEL;
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_sched.sv
// ============================================================================
// Module   : tb_traffic_phase_sched
// Brief    : Randomized scoreboard bench for traffic_phase_sched.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_phase_sched;

   localparam int TD  = 4;
   localparam int GMN = 3;
   localparam int GMX = 6;
   localparam int YT  = 1;
   localparam int ART = 1;
   localparam int NCYC = 3000;

   logic       clk = 1'b0;
   logic       reset, req0, req1, emg;
   logic [2:0] TRC0, TRC1, phase;
   logic [1:0] pend;

   always #5 clk = ~clk;

   traffic_phase_sched #(
      .TICK_DIV (TD),
      .G_MIN    (GMN),
      .G_MAX    (GMX),
      .Y_T      (YT),
      .AR_T     (ART)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .req0  (req0),
      .req1  (req1),
      .emg   (emg),
      .TRC0  (TRC0),
      .TRC1  (TRC1),
      .phase (phase),
      .pend  (pend)
   );

   typedef struct packed {
      logic [2:0] ph;
      logic [1:0] pd;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference: phase name, cycles spent in it, and outstanding demand per road.
   int m_ph, m_cyc;
   bit m_p0, m_p1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [5:0] lamps(input int ph);
      case (ph)
         0:       return {3'b001, 3'b100};
         1:       return {3'b010, 3'b100};
         3:       return {3'b100, 3'b001};
         4:       return {3'b100, 3'b010};
         default: return {3'b100, 3'b100};
      endcase
   endfunction

   task automatic model_reset();
      m_ph = 0; m_cyc = 0; m_p0 = 0; m_p1 = 0;
   endtask

   task automatic model_step(input bit r0, input bit r1, input bit e);
      int np;
      bit on_tick;
      int ticks;
      np      = m_ph;
      on_tick = ((m_cyc + 1) % TD) == 0;
      ticks   = (m_cyc + 1) / TD;
      if (e) np = 6;
      else if (m_ph == 6) np = 5;
      else if (on_tick) begin
         case (m_ph)
            0: if ((ticks >= GMN && m_p1) || ticks == GMX) np = 1;
            1: if (ticks == YT)  np = 2;
            2: if (ticks == ART) np = 3;
            3: if ((ticks >= GMN && m_p0) || ticks == GMX) np = 4;
            4: if (ticks == YT)  np = 5;
            5: if (ticks == ART) np = 0;
            default: np = 5;
         endcase
      end
      m_p0  = (np == 0 && m_ph != 0) ? 1'b0 : (m_p0 | r0);
      m_p1  = (np == 3 && m_ph != 3) ? 1'b0 : (m_p1 | r1);
      m_cyc = (np != m_ph) ? 0 : m_cyc + 1;
      m_ph  = np;
      sb.push_back({3'(m_ph), m_p1, m_p0});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_trc0"},  32'(TRC0),  32'h1);
      check({tag, "_trc1"},  32'(TRC1),  32'h4);
      check({tag, "_phase"}, 32'(phase), 32'h0);
      check({tag, "_pend"},  32'(pend),  32'h0);
   endtask

   // Monitor: one DUT output sample per clock, matched against the oldest expectation.
   always begin
      exp_t e;
      logic [5:0] l;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         l = lamps(int'(e.ph));
         check("phase", 32'(phase), 32'(e.ph));
         check("trc0",  32'(TRC0),  32'(l[5:3]));
         check("trc1",  32'(TRC1),  32'(l[2:0]));
         check("pend",  32'(pend),  32'(e.pd));
         check("trc0_onehot", 32'($onehot(TRC0)), 32'd1);
         check("trc1_onehot", 32'($onehot(TRC1)), 32'd1);
         check("both_green",  32'(TRC0[0] & TRC1[0]), 32'd0);
      end
   end

   initial begin
      int  emg_left;
      bit  did_y0;
      emg_left = 0;
      did_y0   = 0;
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0; emg = 1'b0;
      model_reset();
      #3;
      check_reset_outputs("por");
      for (int c = 0; c < NCYC; c++) begin
         @(negedge clk);
         reset = 1'b1;
         if (c >= 140 && ((m_ph == 1 && !did_y0) || $urandom_range(0, 499) == 0)) begin
            if (m_ph == 1) did_y0 = 1;
            model_reset();
            sb.push_back('0);
            #2;
            reset = 1'b0;
            #1;
            check_reset_outputs("async_rst");
         end else begin
            if (c < 140) begin
               req0 = 1'b0; req1 = 1'b0; emg = 1'b0;
            end else begin
               req0 = ($urandom_range(0, 15) == 0);
               req1 = ($urandom_range(0, 15) == 0);
               if (emg_left > 0) begin
                  emg = 1'b1;
                  emg_left--;
               end else begin
                  emg = 1'b0;
                  if ($urandom_range(0, 149) == 0) emg_left = $urandom_range(1, 15);
               end
            end
            model_step(req0, req1, emg);
         end
      end
      @(negedge clk);
      @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
